// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine owning the HI/LO register pair.
// Signed operations run on operand magnitudes; the sign is applied in a
// final FIX cycle. Multiply is radix-2 shift-add, divide is restoring
// shift-subtract, one iteration per clock for WIDTH clocks.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_start,
    input  logic [1:0]       sig_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             sig_mt_hi,
    input  logic             sig_mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_reg,
    output logic [WIDTH-1:0] lo_reg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 is_div_q;
    logic                 divz_q;
    logic                 neg_q;
    logic                 neg_r;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Operand decode at launch: sig_op[1] selects divide, sig_op[0] unsigned.
    logic                 op_div;
    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // One iteration of each algorithm plus the sign-fixed results.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Launch-time magnitudes and sign flags.
    always_comb begin
        op_div    = sig_op[1];
        op_signed = ~sig_op[0];
        a_neg     = op_signed & src_a[WIDTH-1];
        b_neg     = op_signed & src_b[WIDTH-1];
        a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
    end

    // Datapath for a single CALC iteration and the FIX-cycle sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        // Restoring divide: shifted partial remainder minus divisor; MSB set means borrow.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        acc_step  = '0;
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = neg_r ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sig_start) begin
                        // Start wins over any MTHI/MTLO in the same cycle.
                        cnt_q    <= '0;
                        b_q      <= b_mag;
                        is_div_q <= op_div;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        if (op_div && (src_b == '0)) begin
                            // Divide by zero: result is fixed, skip the iterations.
                            divz_q  <= 1'b1;
                            acc_q   <= {src_a, {WIDTH{1'b1}}};
                            state_q <= FIX;
                        end else begin
                            divz_q  <= 1'b0;
                            acc_q   <= {{WIDTH{1'b0}}, a_mag};
                            state_q <= CALC;
                        end
                    end else begin
                        if (sig_mt_hi) hi_q <= mt_data;
                        if (sig_mt_lo) lo_q <= mt_data;
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (divz_q) begin
                        hi_q <= acc_q[2*WIDTH-1:WIDTH];
                        lo_q <= acc_q[WIDTH-1:0];
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign hi_reg = hi_q;
    assign lo_reg = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, busy
// length, single done pulse, reset abort, ignored start/MT while busy.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        sig_start;
    logic [1:0]  sig_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        sig_mt_hi;
    logic        sig_mt_lo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_start (sig_start),
        .sig_op    (sig_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .sig_mt_hi (sig_mt_hi),
        .sig_mt_lo (sig_mt_lo),
        .mt_data   (mt_data),
        .busy      (busy),
        .done      (done),
        .hi_reg    (hi_reg),
        .lo_reg    (lo_reg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle monitors sampled mid-cycle
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for busy to drop (bounded), then let the done cycle be sampled.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_busy, input string tag);
        busy_cnt  = 0;
        done_cnt  = 0;
        sig_start = 1'b1;
        sig_op    = op;
        src_a     = a;
        src_b     = b;
        tick();
        sig_start = 1'b0;
        wait_idle(tag);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_hi"}, hi_reg, exp_hi);
        check({tag, "_lo"}, lo_reg, exp_lo);
        tick();
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        sig_start = 1'b0;
        sig_op    = 2'b00;
        src_a     = '0;
        src_b     = '0;
        sig_mt_hi = 1'b0;
        sig_mt_lo = 1'b0;
        mt_data   = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi_reg, 32'd0);
        check("rst_lo", lo_reg, 32'd0);
        rst = 1'b0;
        tick();

        // Unsigned multiply
        run_op(OP_MULTU, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 33, "multu_7x6");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu_max");

        // Signed multiply: -3 * 5 = -15
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, "mult_neg");

        // Divide: -7 / 2 = -3 rem -1; 100 / 7 = 14 rem 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg");
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_100_7");

        // Divide by zero and signed overflow
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_ovf");

        // Reset mid-CALC aborts the operation and clears HI/LO
        busy_cnt  = 0;
        done_cnt  = 0;
        sig_start = 1'b1;
        sig_op    = OP_MULTU;
        src_a     = 32'd5;
        src_b     = 32'd5;
        tick();
        sig_start = 1'b0;
        repeat (5) tick();
        check("abort_busy_mid", {31'd0, busy}, 32'd1);
        check("abort_hold_lo", lo_reg, 32'h8000_0000);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi_reg, 32'd0);
        check("abort_lo", lo_reg, 32'd0);
        repeat (40) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // Start and MTLO while busy are ignored
        busy_cnt  = 0;
        done_cnt  = 0;
        sig_start = 1'b1;
        sig_op    = OP_MULTU;
        src_a     = 32'd3;
        src_b     = 32'd4;
        tick();
        sig_start = 1'b0;
        repeat (9) tick();
        sig_start = 1'b1;
        sig_op    = OP_DIVU;
        src_a     = 32'd100;
        src_b     = 32'd7;
        sig_mt_lo = 1'b1;
        mt_data   = 32'h0000_0055;
        check("busy_hold_lo", lo_reg, 32'd0);
        tick();
        sig_start = 1'b0;
        sig_mt_lo = 1'b0;
        wait_idle("ignore");
        check("ignore_busy_cycles", 32'(busy_cnt), 32'd33);
        check("ignore_done_pulses", 32'(done_cnt), 32'd1);
        check("ignore_hi", hi_reg, 32'd0);
        check("ignore_lo", lo_reg, 32'd12);
        tick();

        // MTHI in IDLE
        sig_mt_hi = 1'b1;
        mt_data   = 32'hDEAD_BEEF;
        tick();
        sig_mt_hi = 1'b0;
        check("mthi_hi", hi_reg, 32'hDEAD_BEEF);
        check("mthi_lo", lo_reg, 32'd12);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        // Both MT enables write both registers
        sig_mt_hi = 1'b1;
        sig_mt_lo = 1'b1;
        mt_data   = 32'h1357_9BDF;
        tick();
        sig_mt_hi = 1'b0;
        sig_mt_lo = 1'b0;
        check("mtboth_hi", hi_reg, 32'h1357_9BDF);
        check("mtboth_lo", lo_reg, 32'h1357_9BDF);

        // Start wins over a simultaneous MTLO
        sig_mt_lo = 1'b1;
        mt_data   = 32'hAAAA_AAAA;
        run_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 33, "start_over_mt");
        sig_mt_lo = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
